// File: rtl/al4s3b_fpga_fifo_if.sv
// Wishbone slave-side bundle for the FPGA FIFO aperture.
// An access is requested while CYC & STB are high; the slave completes it with a
// one-cycle ACK, and the master must drop or re-qualify STB once ACK is seen.
interface al4s3b_fpga_fifo_if #(
   parameter int ADDRWIDTH = 7,
   parameter int DATAWIDTH = 32
);
   logic [ADDRWIDTH-1:0] WBs_ADR_i;
   logic                 WBs_CYC_i;
   logic [3:0]           WBs_BYTE_STB_i;
   logic                 WBs_WE_i;
   logic                 WBs_STB_i;
   logic [DATAWIDTH-1:0] WBs_DAT_i;
   logic [DATAWIDTH-1:0] WBs_DAT_o;
   logic                 WBs_ACK_o;

   modport master (
      output WBs_ADR_i, WBs_CYC_i, WBs_BYTE_STB_i, WBs_WE_i, WBs_STB_i, WBs_DAT_i,
      input  WBs_DAT_o, WBs_ACK_o
   );

   modport slave (
      input  WBs_ADR_i, WBs_CYC_i, WBs_BYTE_STB_i, WBs_WE_i, WBs_STB_i, WBs_DAT_i,
      output WBs_DAT_o, WBs_ACK_o
   );
endinterface

// File: rtl/al4s3b_fpga_fifo.sv
// Wishbone-mapped 32-bit FIFO with sticky error flags, flush control and a
// level-threshold interrupt. Data register push/pop, status, control, threshold.
module al4s3b_fpga_fifo #(
   parameter int          ADDRWIDTH          = 7,
   parameter int          DATAWIDTH          = 32,
   parameter int          FIFO_DEPTH_LOG2    = 6,
   parameter logic [15:0] FIFO_THRESH_DEF    = 16'd32,
   parameter logic [31:0] FIFO_DEF_REG_VALUE = 32'hFAB_DEF_AC
) (
   input  logic                  WBs_CLK_i,
   input  logic                  WBs_RSTn_i,
   al4s3b_fpga_fifo_if.slave     wb,
   output logic                  FIFO_IRQ_o
);

   localparam int N     = FIFO_DEPTH_LOG2;
   localparam int DEPTH = 1 << N;

   localparam logic [ADDRWIDTH-1:0] ADR_DATA   = ADDRWIDTH'(0);
   localparam logic [ADDRWIDTH-1:0] ADR_STATUS = ADDRWIDTH'(1);
   localparam logic [ADDRWIDTH-1:0] ADR_CTRL   = ADDRWIDTH'(2);
   localparam logic [ADDRWIDTH-1:0] ADR_THRESH = ADDRWIDTH'(3);

   localparam logic [N:0] PTR_ONE = {{N{1'b0}}, 1'b1};

   // storage and state
   logic [DATAWIDTH-1:0] mem [DEPTH];
   logic [N:0]           wptr;
   logic [N:0]           rptr;
   logic                 overflow;
   logic                 underflow;
   logic                 irq_en;
   logic [15:0]          thresh;

   // derived status
   logic [N:0]           level;
   logic [15:0]          level_ext;
   logic                 empty;
   logic                 full;
   logic                 thresh_hit;

   // bus decode
   logic [ADDRWIDTH-1:0] adr;
   logic [3:0]           be;
   logic [DATAWIDTH-1:0] wdat;
   logic                 access;
   logic                 wr_acc;
   logic                 rd_acc;
   logic                 sel_data;
   logic                 sel_status;
   logic                 sel_ctrl;
   logic                 sel_thresh;

   // access side effects
   logic                 push_req;
   logic                 push_ok;
   logic                 push_drop;
   logic                 pop_req;
   logic                 pop_ok;
   logic                 pop_miss;
   logic                 flush;
   logic                 clr_sticky;
   logic                 ctrl_wr;
   logic                 thresh_wr;
   logic [DATAWIDTH-1:0] push_data;
   logic [DATAWIDTH-1:0] rd_mux;

   assign adr  = wb.WBs_ADR_i;
   assign be   = wb.WBs_BYTE_STB_i;
   assign wdat = wb.WBs_DAT_i;

   // The ACK term keeps a held STB from being serviced twice.
   assign access = wb.WBs_CYC_i & wb.WBs_STB_i & ~wb.WBs_ACK_o;
   assign wr_acc = access &  wb.WBs_WE_i;
   assign rd_acc = access & ~wb.WBs_WE_i;

   assign sel_data   = (adr == ADR_DATA);
   assign sel_status = (adr == ADR_STATUS);
   assign sel_ctrl   = (adr == ADR_CTRL);
   assign sel_thresh = (adr == ADR_THRESH);

   assign level      = wptr - rptr;
   assign level_ext  = {{(16 - (N + 1)){1'b0}}, level};
   assign empty      = (wptr == rptr);
   assign full       = (wptr[N] != rptr[N]) && (wptr[N-1:0] == rptr[N-1:0]);
   assign thresh_hit = (level_ext >= thresh);

   assign push_req  = wr_acc & sel_data & (|be);
   assign push_ok   = push_req & ~full;
   assign push_drop = push_req &  full;
   assign pop_req   = rd_acc & sel_data;
   assign pop_ok    = pop_req & ~empty;
   assign pop_miss  = pop_req &  empty;

   assign ctrl_wr    = wr_acc & sel_ctrl;
   assign thresh_wr  = wr_acc & sel_thresh;
   assign flush      = ctrl_wr & be[0] & wdat[0];
   assign clr_sticky = ctrl_wr & be[0] & wdat[1];

   // Disabled byte lanes are stored as zero.
   always_comb begin
      push_data = '0;
      for (int i = 0; i < 4; i++) begin
         if (be[i]) push_data[8*i +: 8] = wdat[8*i +: 8];
      end
   end

   // Read mux reflects state before this access's own side effects.
   always_comb begin
      rd_mux = FIFO_DEF_REG_VALUE;
      if (sel_data) begin
         rd_mux = empty ? FIFO_DEF_REG_VALUE : mem[rptr[N-1:0]];
      end else if (sel_status) begin
         rd_mux = {11'b0, thresh_hit, underflow, overflow, full, empty, level_ext};
      end else if (sel_ctrl) begin
         rd_mux = {23'b0, irq_en, 8'b0};
      end else if (sel_thresh) begin
         rd_mux = {16'b0, thresh};
      end
   end

   // Memory is not reset; flush only moves the pointers.
   always_ff @(posedge WBs_CLK_i) begin
      if (push_ok) mem[wptr[N-1:0]] <= push_data;
   end

   always_ff @(posedge WBs_CLK_i or negedge WBs_RSTn_i) begin
      if (!WBs_RSTn_i) begin
         wptr <= '0;
         rptr <= '0;
      end else if (flush) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (push_ok) wptr <= wptr + PTR_ONE;
         if (pop_ok)  rptr <= rptr + PTR_ONE;
      end
   end

   // A clear request takes priority over a coinciding error event.
   always_ff @(posedge WBs_CLK_i or negedge WBs_RSTn_i) begin
      if (!WBs_RSTn_i) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else if (clr_sticky) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (push_drop) overflow  <= 1'b1;
         if (pop_miss)  underflow <= 1'b1;
      end
   end

   always_ff @(posedge WBs_CLK_i or negedge WBs_RSTn_i) begin
      if (!WBs_RSTn_i) begin
         irq_en <= 1'b0;
         thresh <= FIFO_THRESH_DEF;
      end else begin
         if (ctrl_wr && be[1])   irq_en       <= wdat[8];
         if (thresh_wr && be[0]) thresh[7:0]  <= wdat[7:0];
         if (thresh_wr && be[1]) thresh[15:8] <= wdat[15:8];
      end
   end

   always_ff @(posedge WBs_CLK_i or negedge WBs_RSTn_i) begin
      if (!WBs_RSTn_i) begin
         wb.WBs_ACK_o <= 1'b0;
         wb.WBs_DAT_o <= '0;
         FIFO_IRQ_o   <= 1'b0;
      end else begin
         wb.WBs_ACK_o <= access;
         if (rd_acc) wb.WBs_DAT_o <= rd_mux;
         FIFO_IRQ_o   <= irq_en & thresh_hit;
      end
   end

endmodule

// File: tb/tb_al4s3b_fpga_fifo.sv
// Randomized and directed checks of the Wishbone FIFO against a queue-based model.
module tb_al4s3b_fpga_fifo;

   localparam logic [31:0] DEF = 32'hFABDEFAC;

   logic clk = 1'b0;
   logic rst_n;
   logic irq;
   int   n_vec = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   al4s3b_fpga_fifo_if #(.ADDRWIDTH(7), .DATAWIDTH(32)) wb ();

   al4s3b_fpga_fifo dut (
      .WBs_CLK_i  (clk),
      .WBs_RSTn_i (rst_n),
      .wb         (wb),
      .FIFO_IRQ_o (irq)
   );

   // reference model
   logic [31:0] exp_q[$];
   bit          m_ovf;
   bit          m_unf;
   bit          m_irq_en;
   logic [15:0] m_thr;
   logic [31:0] exp_dat;

   task automatic model_reset();
      exp_q.delete();
      m_ovf    = 1'b0;
      m_unf    = 1'b0;
      m_irq_en = 1'b0;
      m_thr    = 16'd32;
      exp_dat  = 32'h0;
   endtask

   function automatic logic model_irq();
      return m_irq_en && (exp_q.size() >= int'(m_thr));
   endfunction

   task automatic model_step(input bit we, input logic [6:0] adr,
                             input logic [31:0] d, input logic [3:0] be);
      logic [31:0] masked;
      logic [31:0] st;
      int          lvl;
      lvl = exp_q.size();
      if (!we) begin
         case (adr)
            7'd0: begin
               if (lvl == 0) begin
                  exp_dat = DEF;
                  m_unf   = 1'b1;
               end else begin
                  exp_dat = exp_q.pop_front();
               end
            end
            7'd1: begin
               st        = 32'h0;
               st[15:0]  = 16'(lvl);
               st[16]    = (lvl == 0);
               st[17]    = (lvl == 64);
               st[18]    = m_ovf;
               st[19]    = m_unf;
               st[20]    = (lvl >= int'(m_thr));
               exp_dat   = st;
            end
            7'd2:    exp_dat = {23'b0, m_irq_en, 8'b0};
            7'd3:    exp_dat = {16'b0, m_thr};
            default: exp_dat = DEF;
         endcase
      end else begin
         case (adr)
            7'd0: begin
               if (be != 4'b0) begin
                  masked = 32'h0;
                  for (int i = 0; i < 4; i++) if (be[i]) masked[8*i +: 8] = d[8*i +: 8];
                  if (lvl == 64) m_ovf = 1'b1;
                  else exp_q.push_back(masked);
               end
            end
            7'd2: begin
               if (be[0] && d[0]) exp_q.delete();
               if (be[0] && d[1]) begin
                  m_ovf = 1'b0;
                  m_unf = 1'b0;
               end
               if (be[1]) m_irq_en = d[8];
            end
            7'd3: begin
               if (be[0]) m_thr[7:0]  = d[7:0];
               if (be[1]) m_thr[15:8] = d[15:8];
            end
            default: ;
         endcase
      end
   endtask

   // driver: one access, with ACK latency/width, read data and IRQ checks
   task automatic bus(input bit we, input logic [6:0] adr, input logic [31:0] d,
                      input logic [3:0] be, output logic [31:0] rd, output logic irq_ack);
      bit   got;
      int   lat;
      logic exp_irq;
      got = 1'b0;
      lat = 0;
      model_step(we, adr, d, be);
      exp_irq = model_irq();
      @(negedge clk);
      wb.WBs_ADR_i      = adr;
      wb.WBs_WE_i       = we;
      wb.WBs_DAT_i      = d;
      wb.WBs_BYTE_STB_i = be;
      wb.WBs_CYC_i      = 1'b1;
      wb.WBs_STB_i      = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         @(posedge clk);
         #1;
         if (wb.WBs_ACK_o === 1'b1) begin
            got = 1'b1;
            lat = i;
            break;
         end
      end
      wb.WBs_CYC_i = 1'b0;
      wb.WBs_STB_i = 1'b0;
      wb.WBs_WE_i  = 1'b0;
      n_vec++;
      if (!got) begin
         n_err++;
         $display("FAIL ack_timeout adr=%0h we=%0b: no ACK within 8 cycles", adr, we);
      end else if (lat != 1) begin
         n_err++;
         $display("FAIL ack_latency adr=%0h: got %0d cycles, want 1", adr, lat);
      end
      n_vec++;
      if (wb.WBs_DAT_o !== exp_dat) begin
         n_err++;
         $display("FAIL dat_o adr=%0h we=%0b: got %h, want %h", adr, we, wb.WBs_DAT_o, exp_dat);
      end
      rd      = wb.WBs_DAT_o;
      irq_ack = irq;
      @(posedge clk);
      #1;
      n_vec++;
      if (wb.WBs_ACK_o !== 1'b0) begin
         n_err++;
         $display("FAIL ack_width adr=%0h: ACK still high a cycle later", adr);
      end
      n_vec++;
      if (irq !== exp_irq) begin
         n_err++;
         $display("FAIL irq after adr=%0h we=%0b: got %b, want %b", adr, we, irq, exp_irq);
      end
   endtask

   task automatic wr(input logic [6:0] adr, input logic [31:0] d, input logic [3:0] be);
      logic [31:0] rd;
      logic        ia;
      bus(1'b1, adr, d, be, rd, ia);
   endtask

   task automatic rd(input logic [6:0] adr, output logic [31:0] data);
      logic ia;
      bus(1'b0, adr, 32'h0, 4'hF, data, ia);
   endtask

   task automatic test_reset();
      logic [31:0] v;
      n_vec++;
      if (wb.WBs_ACK_o !== 1'b0 || wb.WBs_DAT_o !== 32'h0 || irq !== 1'b0) begin
         n_err++;
         $display("FAIL reset_outputs: ack=%b dat=%h irq=%b, want 0/0/0", wb.WBs_ACK_o, wb.WBs_DAT_o, irq);
      end
      rd(7'd1, v);
      n_vec++;
      if (v !== 32'h0001_0000) begin n_err++; $display("FAIL reset_status: got %h, want 00010000", v); end
      rd(7'd3, v);
      n_vec++;
      if (v !== 32'h0000_0020) begin n_err++; $display("FAIL reset_thresh: got %h, want 00000020", v); end
      rd(7'd2, v);
      n_vec++;
      if (v !== 32'h0) begin n_err++; $display("FAIL reset_ctrl: got %h, want 0", v); end
   endtask

   task automatic test_push_pop();
      logic [31:0] words[3];
      logic [31:0] v;
      words[0] = 32'h1111_1111;
      words[1] = 32'h2222_2222;
      words[2] = 32'h3333_3333;
      for (int i = 0; i < 3; i++) wr(7'd0, words[i], 4'hF);
      rd(7'd1, v);
      n_vec++;
      if (v[15:0] !== 16'd3) begin n_err++; $display("FAIL pp_level3: got %0d, want 3", v[15:0]); end
      for (int i = 0; i < 3; i++) begin
         rd(7'd0, v);
         n_vec++;
         if (v !== words[i]) begin n_err++; $display("FAIL pp_order[%0d]: got %h, want %h", i, v, words[i]); end
      end
      rd(7'd1, v);
      n_vec++;
      if (v[15:0] !== 16'd0) begin n_err++; $display("FAIL pp_level0: got %0d, want 0", v[15:0]); end
   endtask

   task automatic test_fill_overflow();
      logic [31:0] v;
      wr(7'd3, 32'h0000_FFFF, 4'b0011);
      for (int i = 0; i <= 64; i++) wr(7'd0, 32'(i), 4'hF);
      rd(7'd1, v);
      n_vec++;
      if (v !== 32'h0006_0040) begin n_err++; $display("FAIL fill_status: got %h, want 00060040", v); end
      for (int i = 0; i < 64; i++) begin
         rd(7'd0, v);
         n_vec++;
         if (v !== 32'(i)) begin n_err++; $display("FAIL fill_pop[%0d]: got %h, want %h", i, v, 32'(i)); end
      end
      rd(7'd1, v);
      n_vec++;
      if (v !== 32'h0005_0000) begin n_err++; $display("FAIL drained_status: got %h, want 00050000", v); end
      wr(7'd2, 32'h2, 4'b0001);
      rd(7'd1, v);
      n_vec++;
      if (v[18] !== 1'b0) begin n_err++; $display("FAIL ovf_clear: got %b, want 0", v[18]); end
      wr(7'd3, 32'd32, 4'b0011);
   endtask

   task automatic test_underflow_wrap();
      logic [31:0] v;
      rd(7'd0, v);
      n_vec++;
      if (v !== DEF) begin n_err++; $display("FAIL empty_pop: got %h, want %h", v, DEF); end
      rd(7'd1, v);
      n_vec++;
      if (v[19] !== 1'b1) begin n_err++; $display("FAIL unf_sticky: got %b, want 1", v[19]); end
      wr(7'd2, 32'h2, 4'b0001);
      for (int rep = 0; rep < 2; rep++) begin
         for (int i = 0; i < 40; i++) wr(7'd0, $urandom, 4'hF);
         for (int i = 0; i < 40; i++) rd(7'd0, v);
      end
      // lane masking: partial strobes store zeros, no strobes push nothing
      wr(7'd0, $urandom, 4'b0101);
      wr(7'd0, $urandom, 4'b0000);
      wr(7'd0, $urandom, 4'b1000);
      rd(7'd0, v);
      rd(7'd0, v);
      rd(7'd1, v);
   endtask

   task automatic test_irq();
      logic [31:0] v;
      logic        ia;
      wr(7'd3, 32'd4, 4'b0011);
      wr(7'd2, 32'h100, 4'b0010);
      for (int i = 0; i < 3; i++) wr(7'd0, 32'hA0 + 32'(i), 4'hF);
      n_vec++;
      if (irq !== 1'b0) begin n_err++; $display("FAIL irq_below: got %b, want 0", irq); end
      bus(1'b1, 7'd0, 32'hA3, 4'hF, v, ia);
      n_vec++;
      if (ia !== 1'b0) begin n_err++; $display("FAIL irq_early: got %b at ACK, want 0", ia); end
      rd(7'd0, v);
      wr(7'd0, 32'hA4, 4'hF);
      wr(7'd2, 32'h101, 4'b0011);
      rd(7'd1, v);
      n_vec++;
      if (v[15:0] !== 16'd0) begin n_err++; $display("FAIL flush_level: got %0d, want 0", v[15:0]); end
      rd(7'd2, v);
      n_vec++;
      if (v !== 32'h100) begin n_err++; $display("FAIL flush_irq_en: got %h, want 00000100", v); end
      wr(7'd3, 32'd0, 4'b0011);
      wr(7'd2, 32'h0, 4'b0010);
      wr(7'd3, 32'd32, 4'b0011);
   endtask

   task automatic test_undef_addr();
      logic [31:0] v;
      rd(7'h10, v);
      n_vec++;
      if (v !== DEF) begin n_err++; $display("FAIL undef_read: got %h, want %h", v, DEF); end
      wr(7'h10, 32'hDEAD_BEEF, 4'hF);
      rd(7'h7F, v);
   endtask

   task automatic test_async_reset();
      logic [31:0] v;
      int          acks;
      acks = 0;
      wr(7'd0, 32'h5555_0001, 4'hF);
      wr(7'd0, 32'h5555_0002, 4'hF);
      @(negedge clk);
      wb.WBs_ADR_i = 7'd0;
      wb.WBs_WE_i  = 1'b0;
      wb.WBs_CYC_i = 1'b1;
      wb.WBs_STB_i = 1'b1;
      #2 rst_n = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
         if (wb.WBs_ACK_o !== 1'b0) acks++;
      end
      wb.WBs_CYC_i = 1'b0;
      wb.WBs_STB_i = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      n_vec++;
      if (acks != 0) begin n_err++; $display("FAIL reset_abort: got %0d ACKs, want 0", acks); end
      n_vec++;
      if (wb.WBs_DAT_o !== 32'h0 || irq !== 1'b0) begin
         n_err++;
         $display("FAIL reset_mid_outputs: dat=%h irq=%b, want 0/0", wb.WBs_DAT_o, irq);
      end
      rd(7'd1, v);
      n_vec++;
      if (v !== 32'h0001_0000) begin n_err++; $display("FAIL reset_mid_empty: got %h, want 00010000", v); end
   endtask

   task automatic test_random();
      logic [31:0] v;
      logic [6:0]  adr;
      logic [3:0]  be;
      logic [31:0] d;
      int          r;
      for (int n = 0; n < 400; n++) begin
         r = $urandom_range(0, 9);
         if (r <= 4)      adr = 7'd0;
         else if (r <= 6) adr = 7'd1;
         else if (r == 7) adr = 7'd2;
         else if (r == 8) adr = 7'd3;
         else             adr = 7'($urandom_range(4, 127));
         be = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
         d  = $urandom;
         if (adr == 7'd3) d[15:0] = 16'($urandom_range(0, 70));
         if (adr == 7'd2 && $urandom_range(0, 3) != 0) d[0] = 1'b0;
         if ($urandom_range(0, 1) == 1) wr(adr, d, be);
         else rd(adr, v);
      end
   endtask

   initial begin
      rst_n             = 1'b0;
      wb.WBs_ADR_i      = '0;
      wb.WBs_CYC_i      = 1'b0;
      wb.WBs_STB_i      = 1'b0;
      wb.WBs_WE_i       = 1'b0;
      wb.WBs_BYTE_STB_i = 4'h0;
      wb.WBs_DAT_i      = '0;
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      test_reset();
      test_push_pop();
      test_fill_overflow();
      test_underflow_wrap();
      test_irq();
      test_undef_addr();
      test_async_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/al4s3b_fpga_fifo.md
# al4s3b_fpga_fifo

Wishbone-slave FIFO peripheral that plugs into the FPGA IP top-level address decode as an additional aperture slot. It is a client of the AHB-to-FPGA Wishbone bus, alongside the register and RAM blocks. The ASSP pushes 32-bit words by writing a data register and pops them by reading the same register. Status, flush, and a level-threshold interrupt are exposed through a small register map. The block's read data and ACK feed the top-level read mux and ACK OR.

## Interface
- `ADDRWIDTH`, default 7: word-address width of `WBs_ADR_i`.
- `DATAWIDTH`, default 32: data width. Fixed at 32.
- `FIFO_DEPTH_LOG2`, default 6: FIFO depth is 2^N words (64).
- `FIFO_THRESH_DEF`, default 16'd32: reset value of the threshold register.
- `FIFO_DEF_REG_VALUE`, default 32'hFAB_DEF_AC: read value for undefined addresses and for an empty pop.
- `WBs_CLK_i`, in, 1: Wishbone clock. This is the only clock.
- `WBs_RSTn_i`, in, 1: reset, asynchronous, active-low.
- `WBs_ADR_i`, in, ADDRWIDTH: word address (byte address bits [ADDRWIDTH+1:2]).
- `WBs_CYC_i`, in, 1: aperture-decoded cycle select.
- `WBs_BYTE_STB_i`, in, 4: byte enables.
- `WBs_WE_i`, in, 1: write enable.
- `WBs_STB_i`, in, 1: transfer strobe.
- `WBs_DAT_i`, in, 32: write data.
- `WBs_DAT_o`, out, 32: read data. Reset value 0.
- `WBs_ACK_o`, out, 1: acknowledge. Reset value 0.
- `FIFO_IRQ_o`, out, 1: level interrupt, registered. Reset value 0.

## Operation
- Register map (word address):
  - **0x00 FIFO_DATA**
    - Write pushes `WBs_DAT_i`, provided any byte strobe is set. Disabled byte lanes are stored as 0.
    - Read pops the head word.
  - **0x01 FIFO_STATUS** (read-only)
    - [15:0] level, zero-extended.
    - [16] empty; [17] full.
    - [18] overflow (sticky); [19] underflow (sticky).
    - [20] thresh_hit (level >= threshold).
    - Other bits read 0.
  - **0x02 FIFO_CTRL**
    - Write, byte lane 0: bit0 flush (self-clearing, not stored); bit1 clear both sticky bits (self-clearing).
    - Write, byte lane 1: bit8 irq_en (stored).
    - Read returns {23'b0, irq_en, 8'b0}.
  - **0x03 FIFO_THRESH**
    - R/W [15:0] threshold. Byte lanes 0/1 honoured individually.
    - Reads {16'b0, thresh}.
  - **Other addresses**: reads return `FIFO_DEF_REG_VALUE`. Writes are ignored but still ACKed.
- Storage: 2^N x 32 array, with read/write pointers of N bits plus a wrap bit. Level = wptr - rptr, width N+1.
- Push when full: data is dropped, pointers are unchanged, overflow is set.
- Pop when empty: returns `FIFO_DEF_REG_VALUE`, pointers are unchanged, underflow is set.
- Flush: both pointers go to 0 and level becomes 0. Sticky bits and irq_en are unaffected. Memory contents are not cleared.
- If a clear-sticky write coincides with a new error event, the clear wins. Only one bus access can occur per cycle, so push/pop/flush never coincide.
- `FIFO_IRQ_o` is registered: irq_en & (level >= threshold). Threshold 0 means the interrupt is always asserted when enabled.
- Reset (`WBs_RSTn_i` = 0, asynchronous):
  - pointers = 0, sticky bits = 0, irq_en = 0, thresh = `FIFO_THRESH_DEF`;
  - `WBs_ACK_o` = 0, `WBs_DAT_o` = 0, `FIFO_IRQ_o` = 0.
- Reset mid-transaction aborts it with no ACK. The master re-issues the access after reset.

## Timing
- Access trigger: at a rising edge where `WBs_CYC_i` & `WBs_STB_i` & ~`WBs_ACK_o`, the access is performed and `WBs_ACK_o` rises.
  - ACK is a single-cycle pulse, so latency is 1 cycle.
  - Back-to-back accesses produce ACKs every other cycle.
- At that same edge:
  - read data is registered into `WBs_DAT_o`;
  - pointer, sticky, and control updates take effect.
- `WBs_DAT_o` holds its value until the next read ACK.
- Status values read at the ACK edge reflect state before that access's own side effects.
- `FIFO_IRQ_o` updates one cycle after the level or threshold change.
- Pointer wrap: indices wrap modulo 2^N.
  - full = index bits equal and wrap bits differ.
  - empty = pointers fully equal.

## Test plan
- **Reset defaults**: after reset, read STATUS → 0x0001_0000 (empty); read THRESH → 0x0000_0020; read CTRL → 0; `FIFO_IRQ_o` = 0.
- **Push/pop order**: push 0x11111111, 0x22222222, 0x33333333, then pop three times → same values in the same order. STATUS level goes 3 → 0. Each ACK is one cycle wide, one cycle after STB.
- **Fill and overflow**: push 65 words (0..64) → STATUS = 0x0006_0040 (full, overflow, level 64). Popping 64 words returns 0..63, and word 64 is absent. Clear sticky via CTRL = 0x2 → bit18 = 0.
- **Underflow**: pop while empty → read 0xFABDEFAC and STATUS bit19 = 1. Pointer wrap check: push 40 / pop 40, twice, so data stays intact across the wrap.
- **IRQ**: THRESH = 4, CTRL = 0x100, push 3 words → IRQ 0; 4th push → IRQ 1 one cycle after its ACK; one pop → IRQ 0. Flush via CTRL = 0x101 → level 0, IRQ 0, irq_en stays 1.
- **Undefined address and async reset**: read address 0x10 → 0xFABDEFAC with ACK. Assert `WBs_RSTn_i` low mid-STB → ACK never asserts and the FIFO becomes empty.
